// File: rtl/tpl_ram_writer_if.sv
`default_nettype none
// ============================================================================
// tpl_ram_writer_if -- stream, template-RAM and status bundle of the writer.
// Rev 1.0
// ============================================================================
interface tpl_ram_writer_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  s_ready;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_wr_en;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH:0]   length;
  logic [15:0]           checksum;
  logic                  check_ok;
  logic                  overflow;

  // Environment side: stream source, RAM and status consumer.
  modport master (
    output start, s_valid, s_data, s_last, ram_rd_data,
    input  s_ready, ram_addr, ram_wr_en, ram_wr_data,
    input  busy, done, length, checksum, check_ok, overflow
  );

  // Writer side.
  modport slave (
    input  start, s_valid, s_data, s_last, ram_rd_data,
    output s_ready, ram_addr, ram_wr_en, ram_wr_data,
    output busy, done, length, checksum, check_ok, overflow
  );
endinterface
`default_nettype wire

// File: rtl/tpl_ram_writer.sv
`default_nettype none
// ============================================================================
// tpl_ram_writer -- captures a template stream into RAM, then verifies it by
// reading it back and comparing 16-bit byte sums.  Rev 1.0
// ============================================================================
module tpl_ram_writer #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic              clk,
  input  logic              tb_rst,
  tpl_ram_writer_if.slave   bus
);
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITE     = 2'd1,
    S_READBACK  = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0]   c_CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = 1;

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_term;
  logic                  r_rd_pend;
  logic                  r_rd_final;
  logic [15:0]           r_rd_sum;
  logic                  r_s_ready;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH:0]   r_length;
  logic [15:0]           r_wsum;
  logic                  r_check_ok;
  logic                  r_overflow;

  logic                  w_hs;
  logic                  w_full;
  logic                  w_last_addr;
  logic [15:0]           w_rd_sum_next;

  assign w_hs          = bus.s_valid & r_s_ready;
  assign w_full        = (r_count[ADDR_WIDTH-1:0] == '1);
  assign w_last_addr   = ({1'b0, r_addr} == (r_length - c_CNT_ONE));
  assign w_rd_sum_next = r_rd_sum + 16'(bus.ram_rd_data);

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_term     <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_rd_final <= 1'b0;
      r_rd_sum   <= '0;
      r_s_ready  <= 1'b0;
      r_addr     <= '0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_length   <= '0;
      r_wsum     <= '0;
      r_check_ok <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wr_en <= 1'b0;
          if (bus.start) begin
            r_state    <= S_WRITE;
            r_busy     <= 1'b1;
            r_s_ready  <= 1'b1;
            r_count    <= '0;
            r_term     <= 1'b0;
            r_wsum     <= '0;
            r_rd_sum   <= '0;
            r_overflow <= 1'b0;
            r_check_ok <= 1'b0;
          end
        end
        S_WRITE: begin
          r_wr_en <= w_hs;
          if (w_hs) begin
            r_addr    <= r_count[ADDR_WIDTH-1:0];
            r_wr_data <= bus.s_data;
            r_count   <= r_count + c_CNT_ONE;
            r_wsum    <= r_wsum + 16'(bus.s_data);
            // A full RAM ends the frame too; only then is it an overflow.
            if (bus.s_last || w_full) begin
              r_s_ready  <= 1'b0;
              r_term     <= 1'b1;
              r_overflow <= ~bus.s_last;
            end
          end else if (r_term) begin
            // Terminal write has been on the bus for one cycle.
            r_state    <= S_READBACK;
            r_length   <= r_count;
            r_addr     <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_final <= 1'b0;
          end
        end
        S_READBACK: begin
          if (r_rd_pend) begin
            r_rd_sum <= w_rd_sum_next;
          end
          // RAM data lags the address by one cycle, so the sum closes one
          // cycle after the last address is presented.
          if (r_rd_final) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_rd_pend  <= 1'b0;
            r_check_ok <= (w_rd_sum_next == r_wsum);
          end else begin
            r_rd_pend <= 1'b1;
            if (w_last_addr) begin
              r_rd_final <= 1'b1;
            end else begin
              r_addr <= r_addr + c_ADDR_ONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready     = r_s_ready;
  assign bus.ram_addr    = r_addr;
  assign bus.ram_wr_en   = r_wr_en;
  assign bus.ram_wr_data = r_wr_data;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.length      = r_length;
  assign bus.checksum    = r_wsum;
  assign bus.check_ok    = r_check_ok;
  assign bus.overflow    = r_overflow;
endmodule
`default_nettype wire
